cart_rom_loader: RTL and testbench
==================================

# cart_rom_loader

Upstream stage of the mapper-0 cartridge: accepts an iNES image as a byte stream and parses the 16-byte header. Writes PRG and CHR data into the cartridge PRG/CHR BRAMs through their write ports and drives the `mapper_config`, `PRG_mask`, `CHR_mask` and `PRGRAM_mask` words that the cartridge consumes. Holds `mapper_config[31]` (cart_init) high until the image is fully loaded, which keeps the NES-side BRAM reads disabled.

## Interface

Parameters:
- `PRG_MAX_UNITS`, 2: maximum PRG size in 16 KiB units; power of two.
- `CHR_MAX_UNITS`, 1: maximum CHR size in 8 KiB units; power of two.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load.
- `s_data`  in  8  image byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`.
- `prg_addr`, `chr_addr`  out  32  BRAM word address (byte index >> 2).
- `prg_din`, `chr_din`  out  32  write data; the byte is replicated on all four lanes.
- `prg_we`, `chr_we`  out  4  one-hot byte-lane enable.
- `prg_en`, `chr_en`  out  1  high whenever the matching `we` is nonzero.
- `mapper_config`  out  32  bit 31 = cart_init; bit 0 = mirrorv; bit 1 = battery; bit 3 = four-screen; bits [15:8] = mapper number; all other bits 0.
- `PRG_mask`, `CHR_mask`, `PRGRAM_mask`  out  32  byte-address masks.
- `busy`, `done`, `error`  out  1  status flags.

## Operation

- FSM states and behaviour:
  - IDLE: `s_ready`=0. On `start`, go to HDR and clear the byte counter.
  - HDR: `s_ready`=1; counts 16 header bytes.
    - Bytes 0-3 must equal 0x4E, 0x45, 0x53, 0x1A. A mismatch on any accepted byte goes to ERR immediately.
    - Byte 4 = PRG units n. Byte 5 = CHR units m. Byte 6 = flags6. Byte 7 = flags7. Bytes 8-15 are ignored.
    - On accepting byte 15, validate n and m:
      - n must be a power of two with 1 ≤ n ≤ PRG_MAX_UNITS.
      - m must be 0 or a power of two ≤ CHR_MAX_UNITS.
      - flags7[3:2] == 2'b10 (NES 2.0) is rejected.
      - Any failure goes to ERR.
    - Otherwise latch the config and masks, then go to TRAIN if flags6[2] is set, else PRG.
  - TRAIN: accepts and discards 512 bytes, then goes to PRG.
  - PRG: writes n×16384 bytes to PRG BRAM at byte index 0 upward. After the last byte, go to CHR if m≠0, else DONE.
  - CHR: writes m×8192 bytes to CHR BRAM at byte index 0 upward, then goes to DONE.
  - DONE: `s_ready`=0, cart_init=0, `done`=1.
  - ERR: `s_ready`=0, cart_init=1, `error`=1.
  - From DONE or ERR, `start` goes to HDR and sets cart_init=1, clears `done`/`error`, and zeroes the masks.
- `start` is ignored in HDR, TRAIN, PRG and CHR.
- Derived values at the end of the header:
  - `PRG_mask` = n×16384−1.
  - `CHR_mask` = (m ? m×8192 : 8192)−1. CHR RAM case: no CHR writes occur.
  - `PRGRAM_mask` = flags6[1] ? 0x1FFF : 0.
  - Mapper number = {flags7[7:4], flags6[7:4]}.
  - mirrorv = flags6[0].
- Only mapper 0 is loaded. A nonzero mapper number is still reported in `mapper_config` and does not cause an error.
- Byte counters are 20 bits. The byte index resets to 0 at each entry to PRG and to CHR.
- `busy` = state ∈ {HDR, TRAIN, PRG, CHR}.

## Timing

- Reset values:
  - `s_ready`, all `we`/`en`, `busy`, `done`, `error`: 0.
  - All `addr`/`din`: 0.
  - All masks: 0.
  - `mapper_config`: 0x8000_0000.
  - State: IDLE.
- `s_ready` is registered and is 1 in HDR, TRAIN, PRG and CHR. It drops in the same cycle the state changes to DONE or ERR. No backpressure exists during load: one byte per cycle is sustained.
- Write latency: a byte accepted at cycle t produces its BRAM write at cycle t+1.
  - `addr` = idx>>2.
  - `we` = 1<<idx[1:0].
  - `din` = {4{byte}}.
  - `we` is 0 in every cycle without a corresponding accepted byte.
- Header validation result: the state at t+1 reflects the byte-15 acceptance at t. Masks and config are valid from t+1.
- cart_init falls in the cycle after the final CHR byte is accepted (or the final PRG byte when m=0). This is the same cycle as that byte's BRAM write.
- `s_valid` low stalls the counters; the state is held indefinitely.
- `rst` in any state returns to reset values on the next edge. BRAM contents are not cleared.

## Structure

- Package `cart_pkg`:
  - loader state enum.
  - iNES magic constant.
  - Header byte offsets.
  - `PRG_UNIT_BYTES`=16384, `CHR_UNIT_BYTES`=8192, `TRAINER_BYTES`=512.
  - `mapper_config` bit positions.
- Sub-module `bram_byte_writer`: registers {valid, byte index, byte} and produces addr/din/we/en for one BRAM. It is instantiated once for PRG and once for CHR.

## Test plan

- Valid 32 KiB NROM image (n=2, m=1, flags6=0x01), streamed continuously:
  - `PRG_mask`=0x7FFF, `CHR_mask`=0x1FFF, `mapper_config`=0x0000_0001 after the last byte.
  - PRG byte 0x7FFF is written at addr 0x1FFF with we=4'b1000.
  - `done`=1; no writes are left after cart_init falls.
- n=1, m=0 image with random `s_valid` gaps:
  - `PRG_mask`=0x3FFF, `CHR_mask`=0x1FFF.
  - Zero CHR writes; every PRG byte is written exactly once.
- Corrupted magic (byte 2 = 0x54): ERR on the cycle after byte 2, `error`=1, `s_ready`=0, cart_init stays 1.
- n=3, or n=4 with PRG_MAX_UNITS=2: ERR after byte 15, and no PRG writes occur.
- flags6=0x04 (trainer): the first 512 post-header bytes produce no writes, and the next byte is written to PRG addr 0 with we=4'b0001.
- `rst` asserted mid-PRG, then `start` with a fresh image: outputs are at reset values the cycle after `rst`, and the full reload completes with the correct masks.

Source files
------------

// File: rtl/cart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cart_pkg
// Brief    : Shared types and constants for the iNES cartridge loader.
// Revision : 1.0
// ============================================================================
package cart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_TRAIN = 3'd2,
        ST_PRG   = 3'd3,
        ST_CHR   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_t;

    localparam int CNT_W = 20;

    // "NES\x1A" with header byte 0 in the least significant lane
    localparam logic [31:0] INES_MAGIC = 32'h1A53_454E;

    localparam logic [CNT_W-1:0] HDR_MAGIC_LEN = 20'd4;
    localparam logic [CNT_W-1:0] HDR_PRG_UNITS = 20'd4;
    localparam logic [CNT_W-1:0] HDR_CHR_UNITS = 20'd5;
    localparam logic [CNT_W-1:0] HDR_FLAGS6    = 20'd6;
    localparam logic [CNT_W-1:0] HDR_FLAGS7    = 20'd7;
    localparam logic [CNT_W-1:0] HDR_LAST      = 20'd15;

    localparam int PRG_UNIT_BYTES = 16384;
    localparam int CHR_UNIT_BYTES = 8192;
    localparam int TRAINER_BYTES  = 512;

    localparam int CFG_MIRRORV     = 0;
    localparam int CFG_BATTERY     = 1;
    localparam int CFG_FOUR_SCREEN = 3;
    localparam int CFG_MAPPER_LSB  = 8;
    localparam int CFG_CART_INIT   = 31;

    localparam logic [31:0] CFG_RESET = 32'h8000_0000;

    function automatic logic is_pow2(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_byte_writer.sv
`default_nettype none
// ============================================================================
// Module   : bram_byte_writer
// Brief    : Turns one accepted byte into a single-lane 32-bit BRAM write.
// Revision : 1.0
// ============================================================================
module bram_byte_writer
    import cart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_valid,
    input  logic [CNT_W-1:0] i_wr_idx,
    input  logic [7:0]       i_wr_byte,
    output logic [31:0]      o_addr,
    output logic [31:0]      o_din,
    output logic [3:0]       o_we,
    output logic             o_en
);

    logic             r_valid;
    logic [CNT_W-1:0] r_idx;
    logic [7:0]       r_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_byte  <= 8'd0;
        end else begin
            r_valid <= i_wr_valid;
            r_idx   <= i_wr_idx;
            r_byte  <= i_wr_byte;
        end
    end

    assign o_addr = {{(34-CNT_W){1'b0}}, r_idx[CNT_W-1:2]};
    assign o_din  = {4{r_byte}};
    assign o_we   = r_valid ? (4'b0001 << r_idx[1:0]) : 4'b0000;
    assign o_en   = r_valid;

endmodule
`default_nettype wire

// File: rtl/cart_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : cart_rom_loader
// Brief    : Parses an iNES byte stream and loads PRG/CHR BRAMs for mapper 0.
// Revision : 1.0
// ============================================================================
module cart_rom_loader
    import cart_pkg::*;
#(
    parameter int PRG_MAX_UNITS = 2,
    parameter int CHR_MAX_UNITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] prg_addr,
    output logic [31:0] prg_din,
    output logic [3:0]  prg_we,
    output logic        prg_en,
    output logic [31:0] chr_addr,
    output logic [31:0] chr_din,
    output logic [3:0]  chr_we,
    output logic        chr_en,
    output logic [31:0] mapper_config,
    output logic [31:0] PRG_mask,
    output logic [31:0] CHR_mask,
    output logic [31:0] PRGRAM_mask,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [7:0]       c_prg_max_units = 8'(PRG_MAX_UNITS);
    localparam logic [7:0]       c_chr_max_units = 8'(CHR_MAX_UNITS);
    localparam logic [CNT_W-1:0] c_trainer_last  = CNT_W'(TRAINER_BYTES - 1);

    loader_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_prg_units;
    logic [7:0]       r_chr_units;
    logic [7:0]       r_flags6;
    logic [7:2]       r_flags7;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [31:0]      r_cfg;
    logic [31:0]      r_prg_mask;
    logic [31:0]      r_chr_mask;
    logic [31:0]      r_prgram_mask;

    logic w_accept;
    logic w_magic_ok;
    logic w_prg_ok;
    logic w_chr_ok;
    logic w_hdr_ok;
    logic w_prg_wr;
    logic w_chr_wr;

    assign w_accept   = s_valid & r_ready;
    assign w_magic_ok = (s_data == INES_MAGIC[{r_cnt[1:0], 3'b000} +: 8]);
    assign w_prg_ok   = is_pow2(r_prg_units) && (r_prg_units <= c_prg_max_units);
    assign w_chr_ok   = (r_chr_units == 8'd0) ||
                        (is_pow2(r_chr_units) && (r_chr_units <= c_chr_max_units));
    // flags7[3:2] == 2'b10 marks an NES 2.0 header, which this loader does not parse
    assign w_hdr_ok   = w_prg_ok && w_chr_ok && (r_flags7[3:2] != 2'b10);
    assign w_prg_wr   = w_accept && (r_state == ST_PRG);
    assign w_chr_wr   = w_accept && (r_state == ST_CHR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_prg_units   <= 8'd0;
            r_chr_units   <= 8'd0;
            r_flags6      <= 8'd0;
            r_flags7      <= 6'd0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_cfg         <= CFG_RESET;
            r_prg_mask    <= 32'd0;
            r_chr_mask    <= 32'd0;
            r_prgram_mask <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        r_state       <= ST_HDR;
                        r_cnt         <= '0;
                        r_ready       <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_error       <= 1'b0;
                        r_cfg         <= CFG_RESET;
                        r_prg_mask    <= 32'd0;
                        r_chr_mask    <= 32'd0;
                        r_prgram_mask <= 32'd0;
                    end
                end
                ST_HDR: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        case (r_cnt)
                            HDR_PRG_UNITS: r_prg_units <= s_data;
                            HDR_CHR_UNITS: r_chr_units <= s_data;
                            HDR_FLAGS6:    r_flags6    <= s_data;
                            HDR_FLAGS7:    r_flags7    <= s_data[7:2];
                            default:       ;
                        endcase
                        if ((r_cnt < HDR_MAGIC_LEN) && !w_magic_ok) begin
                            r_state <= ST_ERR;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else if (r_cnt == HDR_LAST) begin
                            r_cnt <= '0;
                            if (!w_hdr_ok) begin
                                r_state <= ST_ERR;
                                r_ready <= 1'b0;
                                r_busy  <= 1'b0;
                                r_error <= 1'b1;
                            end else begin
                                r_prg_mask <= 32'(r_prg_units) * 32'(PRG_UNIT_BYTES) - 32'd1;
                                r_chr_mask <= (r_chr_units != 8'd0)
                                            ? 32'(r_chr_units) * 32'(CHR_UNIT_BYTES) - 32'd1
                                            : 32'(CHR_UNIT_BYTES) - 32'd1;
                                r_prgram_mask <= r_flags6[1] ? 32'h0000_1FFF : 32'd0;
                                r_cfg <= CFG_RESET;
                                r_cfg[CFG_MAPPER_LSB +: 8]  <= {r_flags7[7:4], r_flags6[7:4]};
                                r_cfg[CFG_FOUR_SCREEN]      <= r_flags6[3];
                                r_cfg[CFG_BATTERY]          <= r_flags6[1];
                                r_cfg[CFG_MIRRORV]          <= r_flags6[0];
                                r_state <= r_flags6[2] ? ST_TRAIN : ST_PRG;
                            end
                        end
                    end
                end
                ST_TRAIN: begin
                    if (w_accept) begin
                        if (r_cnt == c_trainer_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_PRG;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_PRG: begin
                    if (w_accept) begin
                        if (r_cnt == r_prg_mask[CNT_W-1:0]) begin
                            r_cnt <= '0;
                            if (r_chr_units != 8'd0) begin
                                r_state <= ST_CHR;
                            end else begin
                                r_state              <= ST_DONE;
                                r_ready              <= 1'b0;
                                r_busy               <= 1'b0;
                                r_done               <= 1'b1;
                                r_cfg[CFG_CART_INIT] <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_CHR: begin
                    if (w_accept) begin
                        if (r_cnt == r_chr_mask[CNT_W-1:0]) begin
                            r_cnt                <= '0;
                            r_state              <= ST_DONE;
                            r_ready              <= 1'b0;
                            r_busy               <= 1'b0;
                            r_done               <= 1'b1;
                            r_cfg[CFG_CART_INIT] <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    bram_byte_writer u_prg_writer (
        .clk        (clk),
        .rst        (rst),
        .i_wr_valid (w_prg_wr),
        .i_wr_idx   (r_cnt),
        .i_wr_byte  (s_data),
        .o_addr     (prg_addr),
        .o_din      (prg_din),
        .o_we       (prg_we),
        .o_en       (prg_en)
    );

    bram_byte_writer u_chr_writer (
        .clk        (clk),
        .rst        (rst),
        .i_wr_valid (w_chr_wr),
        .i_wr_idx   (r_cnt),
        .i_wr_byte  (s_data),
        .o_addr     (chr_addr),
        .o_din      (chr_din),
        .o_we       (chr_we),
        .o_en       (chr_en)
    );

    assign s_ready       = r_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign mapper_config = r_cfg;
    assign PRG_mask      = r_prg_mask;
    assign CHR_mask      = r_chr_mask;
    assign PRGRAM_mask   = r_prgram_mask;

endmodule
`default_nettype wire

// File: tb/tb_cart_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cart_rom_loader
// Brief    : Directed self-checking bench for the iNES cartridge loader.
// Revision : 1.0
// ============================================================================
module tb_cart_rom_loader;

    typedef struct {
        logic [7:0]  n;
        logic [7:0]  m;
        logic [7:0]  f6;
        logic [7:0]  f7;
        logic        exp_err;
        logic [31:0] exp_prg;
        logic [31:0] exp_chr;
        logic [31:0] exp_pram;
        logic [31:0] exp_cfg;
    } hdr_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] prg_addr, prg_din, chr_addr, chr_din;
    logic [3:0]  prg_we, chr_we;
    logic        prg_en, chr_en;
    logic [31:0] mapper_config, PRG_mask, CHR_mask, PRGRAM_mask;
    logic        busy, done, error;

    always #5 clk = ~clk;

    cart_rom_loader #(.PRG_MAX_UNITS(2), .CHR_MAX_UNITS(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .prg_addr      (prg_addr),
        .prg_din       (prg_din),
        .prg_we        (prg_we),
        .prg_en        (prg_en),
        .chr_addr      (chr_addr),
        .chr_din       (chr_din),
        .chr_we        (chr_we),
        .chr_en        (chr_en),
        .mapper_config (mapper_config),
        .PRG_mask      (PRG_mask),
        .CHR_mask      (CHR_mask),
        .PRGRAM_mask   (PRGRAM_mask),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    int checks   = 0;
    int failures = 0;

    byte unsigned prg_wcnt [32768];
    byte unsigned prg_byte [32768];
    byte unsigned chr_wcnt [8192];
    byte unsigned chr_byte [8192];
    int prg_total, chr_total, late_writes, mon_bad;
    bit init_low_prev;
    int m_lane, m_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pdat(input int k);
        return 8'(k ^ (k >> 8) ^ 32'h5A);
    endfunction

    function automatic logic [7:0] cdat(input int k);
        return 8'((k * 3) ^ (k >> 7) ^ 32'hC3);
    endfunction

    function automatic int lane_of(input logic [3:0] we);
        case (we)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    // Shadow BRAMs: record every write seen on either port
    always @(negedge clk) begin
        if (prg_we != 4'b0000) begin
            m_lane = lane_of(prg_we);
            if (m_lane < 0 || !prg_en || prg_din != {4{prg_din[7:0]}}) begin
                mon_bad++;
            end else begin
                m_idx = int'(prg_addr) * 4 + m_lane;
                if (m_idx < 32768) begin
                    prg_wcnt[m_idx] = prg_wcnt[m_idx] + 8'd1;
                    prg_byte[m_idx] = prg_din[7:0];
                end else mon_bad++;
            end
            prg_total++;
            if (init_low_prev) late_writes++;
        end else if (prg_en) mon_bad++;
        if (chr_we != 4'b0000) begin
            m_lane = lane_of(chr_we);
            if (m_lane < 0 || !chr_en || chr_din != {4{chr_din[7:0]}}) begin
                mon_bad++;
            end else begin
                m_idx = int'(chr_addr) * 4 + m_lane;
                if (m_idx < 8192) begin
                    chr_wcnt[m_idx] = chr_wcnt[m_idx] + 8'd1;
                    chr_byte[m_idx] = chr_din[7:0];
                end else mon_bad++;
            end
            chr_total++;
            if (init_low_prev) late_writes++;
        end else if (chr_en) mon_bad++;
        init_low_prev = !mapper_config[31];
    end

    task automatic clear_mon();
        for (int i = 0; i < 32768; i++) begin
            prg_wcnt[i] = 8'd0;
            prg_byte[i] = 8'd0;
        end
        for (int i = 0; i < 8192; i++) begin
            chr_wcnt[i] = 8'd0;
            chr_byte[i] = 8'd0;
        end
        prg_total = 0; chr_total = 0; late_writes = 0; mon_bad = 0;
        init_low_prev = 1'b0;
    endtask

    function automatic int prg_bad(input int nbytes);
        int bad = 0;
        for (int i = 0; i < 32768; i++) begin
            if (prg_wcnt[i] != ((i < nbytes) ? 8'd1 : 8'd0)) bad++;
            else if (i < nbytes && prg_byte[i] != pdat(i)) bad++;
        end
        return bad;
    endfunction

    function automatic int chr_bad(input int nbytes);
        int bad = 0;
        for (int i = 0; i < 8192; i++) begin
            if (chr_wcnt[i] != ((i < nbytes) ? 8'd1 : 8'd0)) bad++;
            else if (i < nbytes && chr_byte[i] != cdat(i)) bad++;
        end
        return bad;
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps && ($urandom_range(0, 7) == 0)) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] n, input logic [7:0] m,
                               input logic [7:0] f6, input logic [7:0] f7, input bit gaps);
        send_byte(8'h4E, gaps); send_byte(8'h45, gaps);
        send_byte(8'h53, gaps); send_byte(8'h1A, gaps);
        send_byte(n, gaps);     send_byte(m, gaps);
        send_byte(f6, gaps);    send_byte(f7, gaps);
        repeat (8) send_byte(8'h00, gaps);
    endtask

    task automatic send_body(input int n, input int m, input bit gaps, input int start_at);
        for (int i = 0; i < n * 16384; i++) begin
            if (i == start_at) start = 1'b1;
            send_byte(pdat(i), gaps);
            start = 1'b0;
        end
        for (int i = 0; i < m * 8192; i++) send_byte(cdat(i), gaps);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hdr_vec_t vecs [9];
        vecs[0] = '{8'd2, 8'd1, 8'h01, 8'h00, 1'b0, 32'h7FFF, 32'h1FFF, 32'h0000, 32'h8000_0001};
        vecs[1] = '{8'd1, 8'd0, 8'h02, 8'h00, 1'b0, 32'h3FFF, 32'h1FFF, 32'h1FFF, 32'h8000_0002};
        vecs[2] = '{8'd3, 8'd1, 8'h00, 8'h00, 1'b1, 32'h0,    32'h0,    32'h0,    32'h8000_0000};
        vecs[3] = '{8'd4, 8'd1, 8'h00, 8'h00, 1'b1, 32'h0,    32'h0,    32'h0,    32'h8000_0000};
        vecs[4] = '{8'd0, 8'd0, 8'h00, 8'h00, 1'b1, 32'h0,    32'h0,    32'h0,    32'h8000_0000};
        vecs[5] = '{8'd1, 8'd2, 8'h00, 8'h00, 1'b1, 32'h0,    32'h0,    32'h0,    32'h8000_0000};
        vecs[6] = '{8'd1, 8'd1, 8'h00, 8'h08, 1'b1, 32'h0,    32'h0,    32'h0,    32'h8000_0000};
        vecs[7] = '{8'd1, 8'd1, 8'hA9, 8'h34, 1'b0, 32'h3FFF, 32'h1FFF, 32'h0000, 32'h8000_3A09};
        vecs[8] = '{8'd2, 8'd0, 8'h0A, 8'hFC, 1'b0, 32'h7FFF, 32'h1FFF, 32'h1FFF, 32'h8000_F00A};

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_flags", {busy, done, error}, 0);
        check("rst_we_en", {prg_we, chr_we, prg_en, chr_en}, 0);
        check("rst_addr_din", prg_addr | chr_addr | prg_din | chr_din, 0);
        check("rst_masks", PRG_mask | CHR_mask | PRGRAM_mask, 0);
        check("rst_cfg", mapper_config, 32'h8000_0000);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            do_reset();
            pulse_start();
            send_header(vecs[v].n, vecs[v].m, vecs[v].f6, vecs[v].f7, 1'b0);
            check($sformatf("hdr%0d_error", v), error, vecs[v].exp_err);
            check($sformatf("hdr%0d_ready", v), s_ready, !vecs[v].exp_err);
            check($sformatf("hdr%0d_busy", v), busy, !vecs[v].exp_err);
            check($sformatf("hdr%0d_prg_mask", v), PRG_mask, vecs[v].exp_prg);
            check($sformatf("hdr%0d_chr_mask", v), CHR_mask, vecs[v].exp_chr);
            check($sformatf("hdr%0d_pram_mask", v), PRGRAM_mask, vecs[v].exp_pram);
            check($sformatf("hdr%0d_cfg", v), mapper_config, vecs[v].exp_cfg);
        end

        // Corrupted magic, then restart out of ERR
        do_reset();
        pulse_start();
        send_byte(8'h4E, 1'b0);
        send_byte(8'h45, 1'b0);
        check("magic_b1_error", error, 0);
        send_byte(8'h54, 1'b0);
        check("magic_error", error, 1);
        check("magic_ready", s_ready, 0);
        check("magic_busy", busy, 0);
        check("magic_cart_init", mapper_config[31], 1);
        send_byte(8'h1A, 1'b0);
        check("magic_error_hold", error, 1);
        pulse_start();
        check("err_restart_busy", {busy, s_ready, error}, 3'b110);
        check("err_restart_cfg", mapper_config, 32'h8000_0000);

        // Full 32 KiB NROM, continuous, with a stray start mid-PRG
        do_reset();
        clear_mon();
        pulse_start();
        send_header(8'd2, 8'd1, 8'h01, 8'h00, 1'b0);
        check("nrom_busy", busy, 1);
        send_body(2, 1, 1'b0, 100);
        check("nrom_prg_mask", PRG_mask, 32'h7FFF);
        check("nrom_chr_mask", CHR_mask, 32'h1FFF);
        check("nrom_cfg", mapper_config, 32'h0000_0001);
        check("nrom_status", {done, busy, error, s_ready}, 4'b1000);
        check("nrom_last_chr_we", chr_we, 4'b1000);
        repeat (4) @(posedge clk);
        #1;
        check("nrom_prg_last", {24'd0, prg_wcnt[32767]}, 1);
        check("nrom_prg_last_data", {24'd0, prg_byte[32767]}, {24'd0, pdat(32767)});
        check("nrom_prg_bytes", prg_bad(32768), 0);
        check("nrom_chr_bytes", chr_bad(8192), 0);
        check("nrom_prg_total", prg_total, 32768);
        check("nrom_chr_total", chr_total, 8192);
        check("nrom_late_writes", late_writes, 0);
        check("nrom_mon_bad", mon_bad, 0);
        pulse_start();
        check("done_restart_flags", {busy, done, s_ready}, 3'b101);
        check("done_restart_masks", PRG_mask | CHR_mask | PRGRAM_mask, 0);
        check("done_restart_cfg", mapper_config, 32'h8000_0000);

        // Trainer skip, reset mid-PRG, then a gappy n=1/m=0 reload
        do_reset();
        clear_mon();
        pulse_start();
        send_header(8'd1, 8'd0, 8'h04, 8'h00, 1'b0);
        check("trn_state", dut.r_state == cart_pkg::ST_TRAIN, 1);
        for (int i = 0; i < 512; i++) send_byte(8'hEE, 1'b0);
        check("trn_no_we", prg_we, 0);
        send_byte(8'h11, 1'b0);
        check("trn_first_we", prg_we, 4'b0001);
        check("trn_first_addr", prg_addr, 0);
        check("trn_first_din", prg_din, 32'h1111_1111);
        check("trn_first_en", prg_en, 1);
        check("trn_discarded", prg_total + chr_total, 0);
        for (int i = 1; i < 10; i++) send_byte(pdat(i), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_flags", {s_ready, busy, done, error}, 0);
        check("midrst_we_en", {prg_we, chr_we, prg_en, chr_en}, 0);
        check("midrst_addr_din", prg_addr | chr_addr | prg_din | chr_din, 0);
        check("midrst_masks", PRG_mask | CHR_mask | PRGRAM_mask, 0);
        check("midrst_cfg", mapper_config, 32'h8000_0000);
        rst = 1'b0;
        clear_mon();
        pulse_start();
        send_header(8'd1, 8'd0, 8'h00, 8'h00, 1'b1);
        send_body(1, 0, 1'b1, -1);
        check("reload_prg_mask", PRG_mask, 32'h3FFF);
        check("reload_chr_mask", CHR_mask, 32'h1FFF);
        check("reload_cfg", mapper_config, 32'h0000_0000);
        check("reload_status", {done, busy, error, s_ready}, 4'b1000);
        repeat (4) @(posedge clk);
        #1;
        check("reload_prg_bytes", prg_bad(16384), 0);
        check("reload_prg_total", prg_total, 16384);
        check("reload_chr_total", chr_total, 0);
        check("reload_late_writes", late_writes, 0);
        check("reload_mon_bad", mon_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
